// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency, single-ported memory between an instruction-fetch
// read port (I-side) and a load/store port (D-side). Also counts requester stall cycles.
module mem_port_arbiter #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ack,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] stall_cycles
);

  typedef enum logic {StIdle, StBusy} state_e;
  typedef enum logic {OwnI, OwnD} owner_e;

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  owner_e               last_q, last_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 i_ack_q, i_ack_d;
  logic                 d_ack_q, d_ack_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_SIZE-1:0] stall_q, stall_d;

  logic i_elig, d_elig, pick_d, waiting;

  // A requester whose ack is high this cycle is retiring, so it must not be re-granted.
  assign i_elig  = i_req & ~i_ack_q;
  assign d_elig  = d_req & ~d_ack_q;
  assign pick_d  = d_elig & (~i_elig | (last_q == OwnI));
  assign waiting = i_elig | d_elig;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall_d     = stall_q + {{(WORD_SIZE - 1){1'b0}}, waiting};

    unique case (state_q)
      StIdle: begin
        if (i_elig || d_elig) begin
          owner_d     = pick_d ? OwnD : OwnI;
          last_d      = pick_d ? OwnD : OwnI;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_d & d_we;
          mem_addr_d  = pick_d ? d_addr : i_addr;
          mem_wdata_d = pick_d ? d_wdata : '0;
          cnt_d       = CntInit;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (owner_q == OwnD) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StIdle;
        end
      end
    endcase
  end

  // reset_n is high-true despite its name.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= StIdle;
      owner_q     <= OwnI;
      last_q      <= OwnI;
      cnt_q       <= 4'd0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      stall_q     <= stall_d;
    end
  end

  assign i_ack        = i_ack_q;
  assign d_ack        = d_ack_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = (state_q == StBusy);
  assign stall_cycles = stall_q;

endmodule
